// File: rtl/sm_mac_accum.sv
// Sign-magnitude multiply-accumulate stage: shift-add multiply of two magnitudes,
// signed saturating accumulate, and a valid/ready result per dot product.
module sm_mac_accum #(
    parameter int MAG_W = 8,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [MAG_W-1:0]        act_mag,
    input  logic                    act_sign,
    input  logic [MAG_W-1:0]        wgt_mag,
    input  logic                    wgt_sign,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    clr_acc,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    sat_flag,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int PROD_W = 2 * MAG_W;
    localparam int CNT_W  = (MAG_W > 1) ? $clog2(MAG_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [MAG_W-1:0]  act_q;
    logic [MAG_W-1:0]  wgt_q;
    logic              psign_q;
    logic              last_q;
    logic [PROD_W-1:0] prod;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic              sat_q;

    logic              accept;
    logic              mul_done;
    logic [PROD_W-1:0] partial;
    logic [ACC_W:0]    prod_ext;
    logic [ACC_W:0]    prod_signed;
    logic [ACC_W:0]    sum;
    logic              pos_ovf;
    logic              neg_ovf;

    assign accept   = in_valid & in_ready;
    assign mul_done = (cnt == CNT_W'(MAG_W - 1));
    assign acc_out  = acc;
    assign sat_flag = sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                state_nxt = last_q ? DONE : IDLE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One shift-add step per MUL cycle, and the one-bit-wider sum whose top two
    // bits disagree exactly when the accumulate leaves the ACC_W-bit range.
    always_comb begin
        partial     = wgt_q[cnt] ? (PROD_W'(act_q) << cnt) : '0;
        prod_ext    = {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        prod_signed = psign_q ? (~prod_ext + 1'b1) : prod_ext;
        sum         = {acc[ACC_W-1], acc} + prod_signed;
        pos_ovf     = ~sum[ACC_W] & sum[ACC_W-1];
        neg_ovf     = sum[ACC_W] & ~sum[ACC_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q   <= '0;
            wgt_q   <= '0;
            psign_q <= 1'b0;
            last_q  <= 1'b0;
            prod    <= '0;
            cnt     <= '0;
            acc     <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_acc) begin
                        acc   <= '0;
                        sat_q <= 1'b0;
                    end
                    if (accept) begin
                        act_q   <= act_mag;
                        wgt_q   <= wgt_mag;
                        psign_q <= act_sign ^ wgt_sign;
                        last_q  <= in_last;
                        prod    <= '0;
                        cnt     <= '0;
                    end
                end
                MUL: begin
                    prod <= prod + partial;
                    cnt  <= cnt + 1'b1;
                end
                ACC: begin
                    if (pos_ovf) begin
                        acc   <= {1'b0, {(ACC_W - 1){1'b1}}};
                        sat_q <= 1'b1;
                    end else if (neg_ovf) begin
                        acc   <= {1'b1, {(ACC_W - 1){1'b0}}};
                        sat_q <= 1'b1;
                    end else begin
                        acc <= sum[ACC_W-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc   <= '0;
                        sat_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_mac_accum.sv
// Directed bench for sm_mac_accum: a 24-bit and a 16-bit accumulator instance share
// one stimulus stream and are scored against an integer saturating model.
module tb_sm_mac_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  act_mag = '0;
    logic        act_sign = 1'b0;
    logic [7:0]  wgt_mag = '0;
    logic        wgt_sign = 1'b0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        clr_acc = 1'b0;
    logic        out_ready = 1'b0;

    logic               in_ready_a, out_valid_a, sat_a;
    logic signed [23:0] acc_a;
    logic               in_ready_b, out_valid_b, sat_b;
    logic signed [15:0] acc_b;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int accept_cyc = 0;

    typedef struct {
        int acc24;
        bit sat24;
        int acc16;
        bit sat16;
    } exp_t;

    exp_t sb[$];

    int m24 = 0;
    int m16 = 0;
    bit ms24 = 1'b0;
    bit ms16 = 1'b0;

    sm_mac_accum #(.MAG_W(8), .ACC_W(24)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .act_mag(act_mag), .act_sign(act_sign),
        .wgt_mag(wgt_mag), .wgt_sign(wgt_sign),
        .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready_a),
        .clr_acc(clr_acc), .acc_out(acc_a), .sat_flag(sat_a),
        .out_valid(out_valid_a), .out_ready(out_ready)
    );

    sm_mac_accum #(.MAG_W(8), .ACC_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .act_mag(act_mag), .act_sign(act_sign),
        .wgt_mag(wgt_mag), .wgt_sign(wgt_sign),
        .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready_b),
        .clr_acc(clr_acc), .acc_out(acc_b), .sat_flag(sat_b),
        .out_valid(out_valid_b), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int sat_add(input int a, input int p, input int w, output bit s);
        int hi;
        int lo;
        int r;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        r  = a + p;
        s  = 1'b0;
        if (r > hi) begin
            r = hi;
            s = 1'b1;
        end else if (r < lo) begin
            r = lo;
            s = 1'b1;
        end
        return r;
    endfunction

    task automatic model_clear();
        m24  = 0;
        m16  = 0;
        ms24 = 1'b0;
        ms16 = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Drive one element at the current falling edge; it is accepted at the next rising edge.
    task automatic apply_stimulus(input int a, input bit as, input int w, input bit ws,
                                  input bit last, input bit clr);
        int p;
        bit s;
        act_mag  = 8'(a);
        act_sign = as;
        wgt_mag  = 8'(w);
        wgt_sign = ws;
        in_last  = last;
        clr_acc  = clr;
        in_valid = 1'b1;
        check_output("in_ready_before_accept_a", {31'b0, in_ready_a}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        accept_cyc = cyc;
        in_valid = 1'b0;
        clr_acc  = 1'b0;
        in_last  = 1'b0;
        if (clr) model_clear();
        p = a * w;
        if (as ^ ws) p = -p;
        m24  = sat_add(m24, p, 24, s);
        ms24 = ms24 | s;
        m16  = sat_add(m16, p, 16, s);
        ms16 = ms16 | s;
        if (last) sb.push_back('{acc24: m24, sat24: ms24, acc16: m16, sat16: ms16});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_output("idle_timeout", {31'b0, in_ready_a}, 32'd1);
    endtask

    task automatic wait_result(input bit chk_busy, output int lat);
        exp_t e;
        logic [23:0] e24;
        logic [15:0] e16;
        lat = 0;
        while (!out_valid_a && lat < 40) begin
            if (chk_busy) check_output("in_ready_busy", {31'b0, in_ready_a}, 32'd0);
            @(negedge clk);
            lat++;
        end
        check_output("out_valid_a", {31'b0, out_valid_a}, 32'd1);
        check_output("out_valid_b", {31'b0, out_valid_b}, 32'd1);
        if (chk_busy) check_output("in_ready_done", {31'b0, in_ready_a}, 32'd0);
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            e24 = e.acc24[23:0];
            e16 = e.acc16[15:0];
            check_output("acc_out_a", {8'h0, acc_a}, {8'h0, e24});
            check_output("sat_flag_a", {31'b0, sat_a}, {31'b0, e.sat24});
            check_output("acc_out_b", {16'h0, acc_b}, {16'h0, e16});
            check_output("sat_flag_b", {31'b0, sat_b}, {31'b0, e.sat16});
        end else begin
            check_output("scoreboard_empty", 32'(sb.size()), 32'd1);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        model_clear();
        check_output("out_valid_after_hs", {31'b0, out_valid_a}, 32'd0);
        check_output("in_ready_after_hs", {31'b0, in_ready_a}, 32'd1);
    endtask

    initial begin
        int lat;
        int t0;

        // Reset values while rst_n is held low.
        #1;
        check_output("rst_acc_a", {8'h0, acc_a}, 32'd0);
        check_output("rst_sat_a", {31'b0, sat_a}, 32'd0);
        check_output("rst_out_valid_a", {31'b0, out_valid_a}, 32'd0);
        check_output("rst_in_ready_a", {31'b0, in_ready_a}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single element 5 x 3");
        apply_stimulus(5, 0, 3, 0, 1, 0);
        wait_result(1, lat);
        check_output("latency_last", 32'(lat), 32'd9);
        check_output("acc_15", {8'h0, acc_a}, 32'd15);
        handshake();

        $display("[TB] two elements -15 + 16129");
        apply_stimulus(5, 0, 3, 1, 0, 0);
        t0 = accept_cyc;
        wait_idle();
        apply_stimulus(127, 0, 127, 0, 1, 0);
        check_output("accept_spacing", 32'(accept_cyc - t0), 32'd10);
        wait_result(0, lat);
        check_output("acc_16114", {8'h0, acc_a}, 32'd16114);
        handshake();

        $display("[TB] encoded -128 times 100");
        apply_stimulus(0, 1, 100, 0, 1, 0);
        wait_result(0, lat);
        check_output("acc_neg128", {8'h0, acc_a}, 32'd0);
        handshake();

        $display("[TB] saturation on the 16-bit instance");
        apply_stimulus(127, 0, 127, 0, 0, 0);
        wait_idle();
        apply_stimulus(127, 0, 127, 0, 0, 0);
        wait_idle();
        apply_stimulus(127, 0, 127, 0, 1, 0);
        wait_result(0, lat);
        check_output("acc_b_sat", {16'h0, acc_b}, 32'd32767);
        check_output("sat_b_set", {31'b0, sat_b}, 32'd1);
        check_output("acc_a_nosat", {8'h0, acc_a}, 32'd48387);
        handshake();
        apply_stimulus(1, 0, 1, 0, 1, 0);
        wait_result(0, lat);
        check_output("sat_b_cleared", {31'b0, sat_b}, 32'd0);
        handshake();

        $display("[TB] backpressure in DONE");
        apply_stimulus(6, 0, 7, 0, 1, 0);
        wait_result(0, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            clr_acc  = ~clr_acc;
            @(negedge clk);
            check_output("bp_acc_stable", {8'h0, acc_a}, 32'd42);
            check_output("bp_out_valid", {31'b0, out_valid_a}, 32'd1);
            check_output("bp_no_accept", {31'b0, in_ready_a}, 32'd0);
        end
        in_valid = 1'b0;
        clr_acc  = 1'b0;
        handshake();
        apply_stimulus(2, 0, 3, 0, 1, 0);
        wait_result(0, lat);
        check_output("acc_fresh_6", {8'h0, acc_a}, 32'd6);
        handshake();

        $display("[TB] reset during MUL");
        apply_stimulus(10, 0, 10, 0, 0, 0);
        wait_idle();
        apply_stimulus(7, 0, 9, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_output("mrst_acc_a", {8'h0, acc_a}, 32'd0);
        check_output("mrst_acc_b", {16'h0, acc_b}, 32'd0);
        check_output("mrst_sat_a", {31'b0, sat_a}, 32'd0);
        check_output("mrst_out_valid_a", {31'b0, out_valid_a}, 32'd0);
        check_output("mrst_in_ready_a", {31'b0, in_ready_a}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(2, 0, 2, 0, 1, 0);
        wait_result(0, lat);
        check_output("acc_after_rst_4", {8'h0, acc_a}, 32'd4);
        handshake();

        $display("[TB] clear together with accept");
        apply_stimulus(5, 0, 10, 0, 0, 0);
        wait_idle();
        apply_stimulus(3, 0, 4, 0, 0, 1);
        wait_idle();
        apply_stimulus(1, 0, 1, 0, 1, 0);
        wait_result(0, lat);
        check_output("acc_clr_13", {8'h0, acc_a}, 32'd13);
        handshake();

        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sm_mac_accum.md
Name: sm_mac_accum

Overview:
- Sequential sign-magnitude multiply-accumulate stage in the subarray MAC datapath. Sits directly downstream of the sign/magnitude encoders.
- Takes two operands per element, each an 8-bit magnitude plus a sign bit (activation, weight). Multiplies the magnitudes by shift-add over MAG_W cycles, applies the XOR of the signs, and adds the result into a saturating two's-complement accumulator.
- When an element is tagged last, presents the dot-product result on a valid/ready output.

Parameters:
- MAG_W, 8, magnitude width; also the number of multiply iterations.
- ACC_W, 24, accumulator and result width, signed two's complement, ACC_W >= 2*MAG_W+1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- act_mag  input  MAG_W  activation magnitude (encoder mul_in).
- act_sign  input  1  activation sign (1 = negative).
- wgt_mag  input  MAG_W  weight magnitude.
- wgt_sign  input  1  weight sign.
- in_last  input  1  marks the final element of a dot product.
- in_valid  input  1  element valid.
- in_ready  output  1  stage can accept an element.
- clr_acc  input  1  synchronous accumulator clear; honoured only in IDLE.
- acc_out  output  ACC_W  signed dot-product result.
- sat_flag  output  1  sticky; set if any accumulate of the current dot product saturated.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - acc, product, counter and latched operands clear to 0.
  - acc_out=0, sat_flag=0, out_valid=0.
  - Reset mid-operation abandons the element and the accumulated sum.
- in_ready is a combinational decode: 1 only in IDLE. out_valid is 1 only in DONE.
- States: IDLE, MUL, ACC, DONE.
- IDLE:
  - If clr_acc=1, acc<=0 and sat_flag<=0.
  - On in_valid & in_ready: latch act_mag, wgt_mag, psign = act_sign ^ wgt_sign, and in_last. Set prod<=0, cnt<=0, go to MUL.
  - If clr_acc and an accepted element occur in the same cycle, the clear takes effect first; the element then accumulates onto 0.
- MUL (exactly MAG_W cycles):
  - Each cycle, if wgt_mag[cnt]=1, prod <= prod + (act_mag << cnt). Then cnt<=cnt+1.
  - prod is 2*MAG_W bits, unsigned.
  - After the cycle with cnt=MAG_W-1, go to ACC.
- ACC (1 cycle):
  - sum = acc + (psign ? -prod : prod), with prod zero-extended to ACC_W+1 bits.
  - If sum > 2^(ACC_W-1)-1, acc <= max positive and sat_flag<=1. If sum < -2^(ACC_W-1), acc <= min negative and sat_flag<=1. Otherwise acc<=sum.
  - Magnitude 0 with psign=1 yields +0; no negative zero exists.
  - If the latched last flag is 1, go to DONE; otherwise go to IDLE.
- DONE:
  - acc_out is continuously driven from acc. It is stable while out_valid=1 and out_ready=0.
  - in_valid is ignored; clr_acc is ignored.
  - On out_ready=1: acc<=0, sat_flag<=0, go to IDLE.
- Latency and throughput:
  - Element accepted at edge k. MUL covers edges k+1..k+MAG_W. ACC completes at edge k+MAG_W+1.
  - For a last element, out_valid rises after edge k+MAG_W+1 (9 for the default).
  - Throughput is one element per MAG_W+2 cycles when in_valid is held high.
- Upstream encoder behaviour: a two's-complement input of -128 arrives as mag=0, sign=1. The stage must treat it as product 0; no special case is needed.

Test Plan:
- Reset, then element act=5/+, wgt=3/+, last=1 -> out_valid high 9 cycles after accept, acc_out=15, sat_flag=0. in_ready low during MUL/ACC/DONE.
- Elements (5/+, 3/-) then (127/+, 127/+, last) -> acc_out=16114. Second accept occurs no earlier than 10 cycles after the first.
- Element act mag=0 sign=1 (encoded -128), wgt=100/+, last -> acc_out=0, sat_flag=0.
- ACC_W=16, three elements of 127/+ x 127/+, last on the third -> acc_out=32767, sat_flag=1. After the handshake and a new single element 1x1, acc_out=1 and sat_flag=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and clr_acc -> acc_out stable, no accept. On out_ready=1, the next element result is fresh (acc restarted from 0).
- Assert rst_n low at the 3rd MUL cycle of an element -> all outputs 0 immediately, state IDLE. Next element 2x2 last -> acc_out=4.
- clr_acc=1 with a non-last element accepted in the same IDLE cycle after prior partial sum 50 -> final result excludes 50.
